generic_rr_mux: RTL and testbench

GENERIC_RR_MUX -- requirements
Module: generic_rr_mux

---
 rtl/crg_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/generic_rr_mux.sv | 135 +++++++++++++
 tb/tb_generic_rr_mux.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crg_pkg.sv
// Shared types and helpers for the round-robin stream mux.
package crg_pkg;

  // Arbitration state: IDLE searches for a new owner, LOCKED holds one
  // source until its end-of-packet beat transfers.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } rr_state_e;

  // Modular index step used by the round-robin search.
  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester after last_sel,
// wrapping at NUMBER. No request means no grant.
module rr_arbiter
  import crg_pkg::*;
#(
  parameter int NUMBER   = 2,
  parameter int SELECT_W = $clog2(NUMBER)
) (
  input  logic [NUMBER-1:0]   req,
  input  logic [SELECT_W-1:0] last_sel,
  output logic                gnt_valid,
  output logic [SELECT_W-1:0] gnt_idx
);

  int                  cand;
  logic [SELECT_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = NUMBER; k >= 1; k--) begin
      cand     = wrap_add(int'(last_sel), k, NUMBER);
      cand_idx = SELECT_W'(cand);
      if (req[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/generic_rr_mux.sv
// Packet-aware round-robin stream mux with a one-entry output register.
//
// state  | meaning
// IDLE   | no packet in progress; grant follows round-robin from last_sel+1
// LOCKED | a multi-beat packet is open; only lock_sel is granted
module generic_rr_mux
  import crg_pkg::*;
#(
  parameter  int WIDTH    = 1,
  parameter  int NUMBER   = 2,
  localparam int SELECT_W = $clog2(NUMBER)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUMBER-1:0]   in_valid,
  input  logic [WIDTH-1:0]    in_data [NUMBER-1:0],
  input  logic [NUMBER-1:0]   in_last,
  output logic [NUMBER-1:0]   in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic [SELECT_W-1:0] out_sel,
  output logic                out_last,
  input  logic                out_ready
);

  rr_state_e           state_q, state_d;
  logic [SELECT_W-1:0] lock_sel_q, lock_sel_d;
  logic [SELECT_W-1:0] last_sel_q, last_sel_d;

  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [SELECT_W-1:0] out_sel_q;
  logic                out_last_q;

  logic                slot_free;
  logic                arb_valid;
  logic [SELECT_W-1:0] arb_idx;
  logic                grant_valid;
  logic [SELECT_W-1:0] grant_idx;
  logic                xfer;

  assign slot_free = !out_valid_q || out_ready;

  rr_arbiter #(
    .NUMBER  (NUMBER),
    .SELECT_W(SELECT_W)
  ) u_arb (
    .req      (in_valid),
    .last_sel (last_sel_q),
    .gnt_valid(arb_valid),
    .gnt_idx  (arb_idx)
  );

  // Current grant: the locked owner, otherwise the round-robin winner.
  always_comb begin
    grant_valid = arb_valid;
    grant_idx   = arb_idx;
    if (state_q == LOCKED) begin
      grant_valid = 1'b1;
      grant_idx   = lock_sel_q;
    end
  end

  // One-hot ready toward the granted source, only when the slot can load.
  always_comb begin
    in_ready = '0;
    if (rst_n && slot_free && grant_valid) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer = |(in_ready & in_valid);

  // Next-state: lock on a non-last beat, release on the last beat.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    last_sel_d = last_sel_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (in_last[grant_idx]) begin
            last_sel_d = grant_idx;
          end else begin
            state_d    = LOCKED;
            lock_sel_d = grant_idx;
          end
        end
      end
      LOCKED: begin
        if (xfer && in_last[grant_idx]) begin
          state_d    = IDLE;
          last_sel_d = lock_sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register; reset gives source 0 first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
      last_sel_q <= SELECT_W'(NUMBER - 1);
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      last_sel_q <= last_sel_d;
    end
  end

  // Output slot: reload whenever free, hold everything while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (slot_free) begin
      out_valid_q <= xfer;
      if (xfer) begin
        out_data_q <= in_data[grant_idx];
        out_sel_q  <= grant_idx;
        out_last_q <= in_last[grant_idx];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_generic_rr_mux.sv
// Bench for generic_rr_mux: a 4-source instance checked every cycle against
// a packet-level model, plus a 3-source instance for the non-power-of-two case.
module tb_generic_rr_mux;

  logic       clk;
  logic       rst_n;

  logic [3:0] iv4, il4, ir4;
  logic [7:0] id4 [3:0];
  logic       ov4, ol4, or4;
  logic [7:0] od4;
  logic [1:0] os4;

  logic [2:0] iv3, il3, ir3;
  logic [7:0] id3 [2:0];
  logic       ov3, ol3, or3;
  logic [7:0] od3;
  logic [1:0] os3;

  int checks = 0;
  int errors = 0;

  // Model: owner of an open packet (-1 when none), last finished owner,
  // and the contents of the output slot.
  int         m_lock;
  int         m_last;
  logic       m_ov;
  logic [7:0] m_od;
  logic [1:0] m_os;
  logic       m_ol;

  generic_rr_mux #(.WIDTH(8), .NUMBER(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_data(id4), .in_last(il4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_last(ol4),
    .out_ready(or4)
  );

  generic_rr_mux #(.WIDTH(8), .NUMBER(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv3), .in_data(id3), .in_last(il3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_last(ol3),
    .out_ready(or3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = -1;
    m_last = 3;
    m_ov   = 1'b0;
    m_od   = 8'h00;
    m_os   = 2'd0;
    m_ol   = 1'b0;
  endtask

  // One clock of dut4 against the model. Inputs are set by the caller.
  task automatic cycle4();
    int         own;
    int         c;
    logic       free;
    logic       acc;
    logic [3:0] er;
    free = !m_ov || or4;
    own  = -1;
    if (m_lock >= 0) begin
      own = m_lock;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (own < 0 && iv4[2'(c)]) own = c;
      end
    end
    er = 4'b0;
    if (rst_n && free && own >= 0) er = 4'(1 << own);
    acc = 1'b0;
    if (er != 4'b0) begin
      if (iv4[2'(own)]) acc = 1'b1;
    end
    #1;
    chk("model_in_ready", 32'(ir4), 32'(er));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (free) begin
        m_ov = acc;
        if (acc) begin
          m_od = id4[2'(own)];
          m_os = 2'(own);
          m_ol = il4[2'(own)];
        end
      end
      if (acc) begin
        if (il4[2'(own)]) begin
          m_last = own;
          m_lock = -1;
        end else begin
          m_lock = own;
        end
      end
    end
    #1;
    chk("model_out_valid", 32'(ov4), 32'(m_ov));
    chk("model_out_data", 32'(od4), 32'(m_od));
    chk("model_out_sel", 32'(os4), 32'(m_os));
    chk("model_out_last", 32'(ol4), 32'(m_ol));
  endtask

  typedef struct packed {
    logic [3:0] iv;
    logic [3:0] il;
    logic       ordy;
    logic [7:0] d2;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [17];
  int   n55;

  initial begin
    // 1-beat packets from all four sources: strict rotation
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 8'hA2, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 8'hA2, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 8'hA2, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 8'hA2, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 8'hA2, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 8'hA2, 4'b0010, 1'b1, 2'd1, 8'hA1};
    // 3-beat packet on source 2 while 0 and 3 request, then 3, then 0
    tbl[6]  = '{4'hD, 4'h9, 1'b1, 8'h10, 4'b0100, 1'b1, 2'd2, 8'h10};
    tbl[7]  = '{4'hD, 4'h9, 1'b1, 8'h11, 4'b0100, 1'b1, 2'd2, 8'h11};
    tbl[8]  = '{4'hD, 4'hD, 1'b1, 8'h12, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[9]  = '{4'h9, 4'h9, 1'b1, 8'hA2, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[10] = '{4'h9, 4'h9, 1'b1, 8'hA2, 4'b0001, 1'b1, 2'd0, 8'hA0};
    // source 1 locks, gaps for 3 cycles, source 0 must wait
    tbl[11] = '{4'h3, 4'h1, 1'b1, 8'hA2, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[12] = '{4'h1, 4'h1, 1'b1, 8'hA2, 4'b0010, 1'b0, 2'd1, 8'hA1};
    tbl[13] = '{4'h1, 4'h1, 1'b1, 8'hA2, 4'b0010, 1'b0, 2'd1, 8'hA1};
    tbl[14] = '{4'h1, 4'h1, 1'b1, 8'hA2, 4'b0010, 1'b0, 2'd1, 8'hA1};
    tbl[15] = '{4'h3, 4'h3, 1'b1, 8'hA2, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[16] = '{4'h1, 4'h1, 1'b1, 8'hA2, 4'b0001, 1'b1, 2'd0, 8'hA0};

    model_reset();
    rst_n = 1'b0;
    iv4 = 4'hF; il4 = 4'hF; or4 = 1'b1;
    id4[0] = 8'hA0; id4[1] = 8'hA1; id4[2] = 8'hA2; id4[3] = 8'hA3;
    iv3 = 3'b000; il3 = 3'b000; or3 = 1'b1;
    id3[0] = 8'h00; id3[1] = 8'h00; id3[2] = 8'h00;

    cycle4();
    cycle4();
    chk("reset_out_valid", 32'(ov4), 32'd0);
    chk("reset_out_sel", 32'(os4), 32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < 17; r++) begin
      iv4 = tbl[r].iv; il4 = tbl[r].il; or4 = tbl[r].ordy; id4[2] = tbl[r].d2;
      #1;
      chk($sformatf("tbl%0d_ready", r), 32'(ir4), 32'(tbl[r].exp_rdy));
      cycle4();
      chk($sformatf("tbl%0d_valid", r), 32'(ov4), 32'(tbl[r].exp_ov));
      if (tbl[r].exp_ov) begin
        chk($sformatf("tbl%0d_sel", r), 32'(os4), 32'(tbl[r].exp_sel));
        chk($sformatf("tbl%0d_data", r), 32'(od4), 32'(tbl[r].exp_data));
      end
    end

    // Backpressure: hold 0x55 for 5 stalled cycles, then release once
    iv4 = 4'h0; il4 = 4'h0; or4 = 1'b1;
    cycle4();
    id4[0] = 8'h55; iv4 = 4'b0001; il4 = 4'b0001;
    cycle4();
    chk("bp_load_data", 32'(od4), 32'h55);
    n55 = 0;
    for (int s = 0; s < 5; s++) begin
      iv4 = 4'b1110; il4 = 4'b1110; or4 = 1'b0;
      #1;
      chk("bp_stall_ready", 32'(ir4), 32'd0);
      if (ov4 && or4 && od4 == 8'h55) n55++;
      cycle4();
      chk("bp_stall_valid", 32'(ov4), 32'd1);
      chk("bp_stall_data", 32'(od4), 32'h55);
      chk("bp_stall_sel", 32'(os4), 32'd0);
    end
    for (int s = 0; s < 2; s++) begin
      iv4 = 4'h0; il4 = 4'h0; or4 = 1'b1;
      #1;
      if (ov4 && or4 && od4 == 8'h55) n55++;
      cycle4();
    end
    chk("bp_emit_count", 32'(n55), 32'd1);

    // Reset during beat 2 of a 4-beat packet from source 1
    iv4 = 4'b0010; il4 = 4'b0000; id4[1] = 8'h21;
    cycle4();
    chk("rst_beat1_sel", 32'(os4), 32'd1);
    chk("rst_beat1_data", 32'(od4), 32'h21);
    id4[1] = 8'h22; rst_n = 1'b0;
    #1;
    chk("rst_ready_low", 32'(ir4), 32'd0);
    cycle4();
    chk("rst_out_valid", 32'(ov4), 32'd0);
    rst_n = 1'b1; iv4 = 4'b0011; il4 = 4'b0001; id4[0] = 8'hA0; id4[1] = 8'h23;
    #1;
    chk("rst_first_grant", 32'(ir4), 32'b0001);
    cycle4();
    chk("rst_first_sel", 32'(os4), 32'd0);
    chk("rst_first_data", 32'(od4), 32'hA0);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      iv4 = 4'($urandom);
      il4 = 4'($urandom);
      for (int i = 0; i < 4; i++) id4[i] = 8'($urandom);
      or4 = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 63) != 0);
      cycle4();
    end
    rst_n = 1'b1; iv4 = 4'h0; il4 = 4'h0; or4 = 1'b1;
    cycle4();

    // Three-source build: source 2 streams continuously at full rate
    for (int k = 0; k < 20; k++) begin
      iv3 = 3'b100;
      il3 = (k % 3 == 2) ? 3'b100 : 3'b000;
      id3[2] = 8'(k + 1);
      #1;
      chk("n3_ready", 32'(ir3), 32'b100);
      cycle4();
      chk("n3_valid", 32'(ov3), 32'd1);
      chk("n3_sel", 32'(os3), 32'd2);
      chk("n3_data", 32'(od3), 32'(k + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
